// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART transmit-side control blocks:
//   - arb_state_t      : state encoding of the transmit arbiter FSM
//   - GAP_CYCLES_DEF   : default idle clocks enforced between launches
//   - BUSY_TIMEOUT_DEF : default clocks allowed for tx_busy to rise after a launch
//   - ANS_*            : answer codes exchanged over the UART link
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int GAP_CYCLES_DEF   = 16;
    localparam int BUSY_TIMEOUT_DEF = 64;

    localparam logic [7:0] ANS_AA = 8'hAA;
    localparam logic [7:0] ANS_CC = 8'hCC;
    localparam logic [7:0] ANS_BC = 8'hBC;
    localparam logic [7:0] ANS_11 = 8'h11;
    localparam logic [7:0] ANS_DD = 8'hDD;

endpackage : uart_ctrl_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner selection: the lowest-index active request at or after
// ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req     [NUM_REQ-1:0] in  : active requests
//   ptr     [IDX_W-1:0]   in  : search start index (0..NUM_REQ-1)
//   winner  [NUM_REQ-1:0] out : one-hot winner, all zero when req is zero
//   win_idx [IDX_W-1:0]   out : binary index of the winner (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

    // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it holding its old value (which would infer a latch).
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                      = 1'b1;
                winner[cand[IDX_W-1:0]]    = 1'b1;
                win_idx                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Arbitrates NUM_REQ byte requesters onto a single UART transmitter. A launch
// registers the winner's byte on tx_data, pulses tx_start and grant for one
// clock, then waits for the transmitter to go busy and idle again, followed by
// an enforced gap of GAP_CYCLES clocks. If tx_busy does not rise within
// BUSY_TIMEOUT clocks, timeout_err pulses and the gap starts anyway.
//
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (req[0]
// highest, no rotating pointer); otherwise round-robin from a pointer that
// moves to winner+1 on every grant.
//
// Ports:
//   clk          in  : system clock, rising edge
//   rst_n        in  : synchronous active-low reset
//   req          in  [NUM_REQ]   : level requests, held until granted
//   req_data     in  [8*NUM_REQ] : byte of requester i at [8i+7:8i]
//   grant        out [NUM_REQ]   : one-hot, one-cycle accept pulse
//   tx_data      out [8]         : launched byte, held until next launch
//   tx_start     out             : one-cycle start strobe
//   tx_busy      in              : transmitter busy
//   idle         out             : high while the FSM is in IDLE
//   timeout_err  out             : one-cycle pulse on busy timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 idle,
    output logic                 timeout_err
);

    localparam int              IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // Counter value on the final clock of each timed phase. A zero-length gap
    // still spends one clock in GAP, so it shares the GAP_CYCLES=1 terminal.
    localparam logic [7:0]      TO_LAST  = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]      GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    arb_state_t         state;
    arb_state_t         state_d;
    logic [7:0]         cnt;
    logic [7:0]         cnt_d;
    logic               launch;
    logic               time_out;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_ptr;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Searching from index 0 every time gives req[0] the highest priority.
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] ptr;

    assign pick_ptr = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (launch) begin
            ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
        end
    end
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .winner  (pick_onehot),
        .win_idx (pick_idx)
    );

    // Next-state logic. cnt is shared by WAIT_BUSY (busy timeout) and GAP;
    // it is cleared on every transition so each phase starts counting at 0.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        launch   = 1'b0;
        time_out = 1'b0;
        case (state)
            IDLE: begin
                // A request dropped before this point never reaches the picker,
                // so it is simply forgotten without touching the pointer.
                if ((|req) && !tx_busy) begin
                    launch  = 1'b1;
                    state_d = WAIT_BUSY;
                    cnt_d   = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt == TO_LAST) begin
                    time_out = 1'b1;
                    state_d  = GAP;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // same pre-edge values, independent of statement order.
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            grant       <= launch ? pick_onehot : '0;
            tx_start    <= launch;
            timeout_err <= time_out;
            if (launch) begin
                tx_data <= req_data[{pick_idx, 3'b000} +: 8];
            end
        end
    end

    assign idle = (state == IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, default gap/timeout):
// a table of single-launch vectors from reset, hand-written multi-cycle
// sequences for the timing corner cases, and a randomized run compared against
// a timestamp-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int N       = 4;
    localparam int GAP     = GAP_CYCLES_DEF;
    localparam int TMO     = BUSY_TIMEOUT_DEF;
    localparam int GAP_EFF = (GAP == 0) ? 1 : GAP;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [8*N-1:0]   req_data = '0;
    logic             tx_busy = 1'b0;
    logic [N-1:0]     grant;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             idle;
    logic             timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .idle        (idle),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         busy;
        logic [N-1:0] exp_grant;
        logic         exp_start;
        logic [7:0]   exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        tx_busy = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int limit, output int cycles);
        cycles = 0;
        while (grant == '0 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    // Winner rule: first active index scanning upward from p, wrapping.
    function automatic int pick_model(input logic [N-1:0] r, input int p);
        int start;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = p;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, first_idle, seen, exp_idx;
        int ptr_m, ready_e, launch_e, bs, be, w;
        bit in_fl, rose;
        logic [N-1:0] exp_g;
        logic         exp_to, exp_idle;
        logic [7:0]   data_hold;

        vecs[0] = '{4'b0001, 1'b0, 4'b0001, 1'b1, ANS_AA};
        vecs[1] = '{4'b0010, 1'b0, 4'b0010, 1'b1, ANS_CC};
        vecs[2] = '{4'b1100, 1'b0, 4'b0100, 1'b1, ANS_BC};
        vecs[3] = '{4'b1000, 1'b0, 4'b1000, 1'b1, ANS_DD};
        vecs[4] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[5] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00};
        vecs[6] = '{4'b1010, 1'b0, 4'b0010, 1'b1, ANS_CC};
        vecs[7] = '{4'b1111, 1'b0, 4'b0001, 1'b1, ANS_AA};

        // ---- reset state ----
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;

        // ---- table: one launch from a fresh reset ----
        req_data = {ANS_DD, ANS_BC, ANS_CC, ANS_AA};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req     = vecs[i].req;
            tx_busy = vecs[i].busy;
            tick();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_idle", i), 32'(idle), 32'(!vecs[i].exp_start));
        end

        // ---- single byte, busy for 10 clocks, then enforced gap ----
        do_reset();
        req_data[7:0] = ANS_AA;
        req = 4'b0001;
        tick();
        check("seq1_grant", 32'(grant), 32'b0001);
        check("seq1_start", 32'(tx_start), 32'd1);
        check("seq1_data", 32'(tx_data), 32'(ANS_AA));
        req = '0;
        tick();
        check("seq1_start_pulse", 32'(tx_start), 32'd0);
        check("seq1_grant_pulse", 32'(grant), 32'd0);
        tx_busy = 1'b1;
        repeat (10) tick();
        check("seq1_data_held", 32'(tx_data), 32'(ANS_AA));
        tx_busy = 1'b0;
        req_data[7:0] = ANS_11;
        req = 4'b0001;
        c = 0;
        first_idle = 0;
        while (!tx_start && c < 100) begin
            tick();
            c++;
            if (idle && first_idle == 0) first_idle = c;
        end
        check("seq1_idle_after_gap", 32'(first_idle), 32'd17);
        check("seq1_relaunch_delay", 32'(c), 32'd18);
        check("seq1_relaunch_data", 32'(tx_data), 32'(ANS_11));
        req = '0;

        // ---- all four held: rotation order ----
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(100, c);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = k % N;
`endif
            check($sformatf("rr%0d_grant", k), 32'(grant), 32'(1) << exp_idx);
            check($sformatf("rr%0d_data", k), 32'(tx_data), 32'h10 + 32'(exp_idx));
            tx_busy = 1'b1;
            tick();
            tick();
            tx_busy = 1'b0;
        end
        req = '0;

        // ---- busy never rises: timeout then gap ----
        do_reset();
        req_data[7:0] = ANS_AA;
        req = 4'b0001;
        tick();
        check("tmo_launch", 32'(tx_start), 32'd1);
        req = '0;
        c = 0;
        seen = 0;
        while (!timeout_err && c < 200) begin
            tick();
            c++;
            if (tx_start) seen++;
        end
        check("tmo_delay", 32'(c), 32'(TMO));
        check("tmo_no_extra_start", 32'(seen), 32'd0);
        tick();
        check("tmo_pulse", 32'(timeout_err), 32'd0);
        c2 = 1;
        while (!idle && c2 < 100) begin
            tick();
            c2++;
        end
        check("tmo_gap_to_idle", 32'(c2), 32'(GAP));

        // ---- busy high in IDLE blocks launch ----
        do_reset();
        tx_busy = 1'b1;
        req = 4'b0010;
        seen = 0;
        repeat (8) begin
            tick();
            if (grant != '0) seen++;
        end
        check("busyidle_no_grant", 32'(seen), 32'd0);
        tx_busy = 1'b0;
        tick();
        check("busyidle_grant", 32'(grant), 32'b0010);
        check("busyidle_start", 32'(tx_start), 32'd1);
        req = '0;

        // ---- reset during WAIT_DONE ----
        do_reset();
        req_data = {ANS_DD, ANS_BC, ANS_CC, ANS_AA};
        req = 4'b0001;
        tick();
        req = '0;
        tx_busy = 1'b1;
        repeat (3) tick();
        check("mrst_busy_phase", 32'(idle), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_start", 32'(tx_start), 32'd0);
        check("mrst_idle", 32'(idle), 32'd1);
        check("mrst_data", 32'(tx_data), 32'h00);
        rst_n = 1'b1;
        tx_busy = 1'b0;
        req = 4'b0100;
        tick();
        check("mrst_first_grant", 32'(grant), 32'b0100);
        check("mrst_first_start", 32'(tx_start), 32'd1);
        // Pointer now past index 2; a reset must bring the search back to 0.
        req = '0;
        tx_busy = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        req = 4'b1001;
        tick();
        check("mrst_ptr_cleared", 32'(grant), 32'b0001);
        req = '0;

        // ---- short request during GAP is dropped ----
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
        repeat (3) tick();
        check("gapdrop_in_gap", 32'(idle), 32'd0);
        req = 4'b0100;
        tick();
        req = '0;
        seen = 0;
        repeat (40) begin
            tick();
            if (grant[2]) seen++;
        end
        check("gapdrop_no_grant2", 32'(seen), 32'd0);

        // ---- randomized run against the timestamp model ----
        do_reset();
        ptr_m = 0; ready_e = 0; launch_e = 0; in_fl = 0; rose = 0;
        bs = 0; be = 0; data_hold = 8'h00;
        for (int n = 1; n <= 3000; n++) begin
            tick();
            exp_g  = '0;
            exp_to = 1'b0;
            if (!in_fl) begin
                if (n >= ready_e && req != '0 && !tx_busy) begin
                    w = pick_model(req, ptr_m);
                    exp_g[w]  = 1'b1;
                    data_hold = req_data[8*w +: 8];
                    ptr_m     = (w + 1) % N;
                    in_fl     = 1;
                    rose      = 0;
                    launch_e  = n;
                end
            end else if (!rose) begin
                if (tx_busy) begin
                    rose = 1;
                end else if (n - launch_e == TMO) begin
                    exp_to  = 1'b1;
                    in_fl   = 0;
                    ready_e = n + GAP_EFF + 1;
                end
            end else if (!tx_busy) begin
                in_fl   = 0;
                ready_e = n + GAP_EFF + 1;
            end
            exp_idle = !in_fl && (n + 1 >= ready_e);

            check($sformatf("rnd_grant@%0d", n), 32'(grant), 32'(exp_g));
            check($sformatf("rnd_start@%0d", n), 32'(tx_start), 32'(exp_g != '0));
            check($sformatf("rnd_timeout@%0d", n), 32'(timeout_err), 32'(exp_to));
            check($sformatf("rnd_idle@%0d", n), 32'(idle), 32'(exp_idle));
            check($sformatf("rnd_data@%0d", n), 32'(tx_data), 32'(data_hold));

            // Requesters: release on grant, raise at random, drop rarely.
            for (int i = 0; i < N; i++) begin
                if (grant[i]) req[i] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            // Transmitter: busy window after each start, or none (timeout case).
            if (tx_start) begin
                if ($urandom_range(0, 7) == 0) begin
                    bs = 0;
                    be = 0;
                end else begin
                    bs = n + int'($urandom_range(1, 5));
                    be = bs + int'($urandom_range(1, 10));
                end
            end
            tx_busy = (n + 1 >= bs) && (n + 1 < be);
            if (!in_fl && !tx_busy && $urandom_range(0, 15) == 0) tx_busy = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
